// File: rtl/word_scroll_display_if.sv
// Bus between the game controller and the scrolling display: buffer writes, run control, status and segments.
// Blink exists only when BLINK_EN is defined.
interface word_scroll_display_if #(
  parameter int AW         = 4,
  parameter int NUM_DIGITS = 4
);
  logic                    WrEn;
  logic [AW-1:0]           WrAddr;
  logic [7:0]              WrData;
  logic [AW:0]             MsgLen;
  logic                    Start;
  logic                    Stop;
  logic                    Hold;
`ifdef BLINK_EN
  logic                    Blink;
`endif
  logic                    Busy;
  logic                    StepPulse;
  logic [7*NUM_DIGITS-1:0] Out7b;

  modport master (
    output WrEn, WrAddr, WrData, MsgLen, Start, Stop, Hold,
`ifdef BLINK_EN
    output Blink,
`endif
    input  Busy, StepPulse, Out7b
  );

  modport slave (
    input  WrEn, WrAddr, WrData, MsgLen, Start, Stop, Hold,
`ifdef BLINK_EN
    input  Blink,
`endif
    output Busy, StepPulse, Out7b
  );
endinterface

// File: rtl/word_scroll_display.sv
// Scrolls a NUM_DIGITS-wide window over an ASCII message buffer onto active-low seven-segment digits.
// Optional macro BLINK_EN adds a Blink input that blanks every other scroll step.
module word_scroll_display #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH  = 16,
  parameter int TICK_DIV   = 25_000_000
) (
  input logic                   Clk,
  input logic                   Rst,
  word_scroll_display_if.slave  bus
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);

  // state     | meaning
  // ST_IDLE   | display blank, waiting for Start with a non-empty message
  // ST_SCROLL | window shown, advancing one char every TICK_DIV clocks
  typedef enum logic {ST_IDLE, ST_SCROLL} state_t;

  state_t                  r_state;
  logic [7:0]              r_buf [MSG_DEPTH];
  logic [LW-1:0]           r_pos;
  logic [LW-1:0]           r_len;
  logic [TW-1:0]           r_tick;
  logic                    r_step;
  logic [7*NUM_DIGITS-1:0] r_out;
  logic [7*NUM_DIGITS-1:0] w_out;
  logic [LW-1:0]           w_len_clamp;
  logic [LW-1:0]           w_pos_next;
  logic                    w_tc;
`ifdef BLINK_EN
  logic                    r_phase;
`endif

  function automatic logic [6:0] seg_decode(input logic [7:0] ch);
    case (ch)
      8'h41: seg_decode = 7'h08;  8'h42: seg_decode = 7'h03;
      8'h43: seg_decode = 7'h46;  8'h44: seg_decode = 7'h21;
      8'h45: seg_decode = 7'h06;  8'h46: seg_decode = 7'h0E;
      8'h47: seg_decode = 7'h10;  8'h48: seg_decode = 7'h0B;
      8'h49: seg_decode = 7'h4F;  8'h4A: seg_decode = 7'h70;
      8'h4C: seg_decode = 7'h47;  8'h4E: seg_decode = 7'h2B;
      8'h4F: seg_decode = 7'h23;  8'h50: seg_decode = 7'h0C;
      8'h51: seg_decode = 7'h18;  8'h52: seg_decode = 7'h2F;
      8'h53: seg_decode = 7'h12;  8'h54: seg_decode = 7'h07;
      8'h55: seg_decode = 7'h41;  8'h59: seg_decode = 7'h11;
      8'h5F: seg_decode = 7'h77;  8'h20: seg_decode = 7'h7F;
      8'h30: seg_decode = 7'h40;  8'h31: seg_decode = 7'h79;
      8'h32: seg_decode = 7'h24;  8'h33: seg_decode = 7'h30;
      8'h34: seg_decode = 7'h19;  8'h35: seg_decode = 7'h12;
      8'h36: seg_decode = 7'h02;  8'h37: seg_decode = 7'h78;
      8'h38: seg_decode = 7'h00;  8'h39: seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign w_len_clamp = (bus.MsgLen > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : bus.MsgLen;
  assign w_tc        = (r_tick == TW'(TICK_DIV - 1));
  assign w_pos_next  = (r_pos + LW'(1) >= r_len) ? '0 : r_pos + LW'(1);

  // Window index walks forward from pos with wrap-by-compare, so a short message just repeats.
  always_comb begin
    logic [LW-1:0] v_idx;
    v_idx = r_pos;
    w_out = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_out[7*(NUM_DIGITS-1-k) +: 7] = seg_decode(r_buf[v_idx[AW-1:0]]);
      v_idx = (v_idx + LW'(1) >= r_len) ? '0 : v_idx + LW'(1);
    end
    if (r_state != ST_SCROLL) w_out = '1;
`ifdef BLINK_EN
    if (r_phase) w_out = '1;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_pos   <= '0;
      r_tick  <= '0;
      r_len   <= '0;
      r_step  <= 1'b0;
      r_out   <= '1;
      for (int i = 0; i < MSG_DEPTH; i++) r_buf[i] <= 8'h20;
`ifdef BLINK_EN
      r_phase <= 1'b0;
`endif
    end else begin
      if (bus.WrEn) r_buf[bus.WrAddr] <= bus.WrData;
      r_out  <= w_out;
      r_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.Start && !bus.Stop && bus.MsgLen != '0) begin
            r_state <= ST_SCROLL;
            r_len   <= w_len_clamp;
            r_pos   <= '0;
            r_tick  <= '0;
`ifdef BLINK_EN
            r_phase <= 1'b0;
`endif
          end
        end
        ST_SCROLL: begin
          // Stop beats a restart, and both beat a step landing on the same edge.
          if (bus.Stop || (bus.Start && bus.MsgLen == '0)) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
            r_tick  <= '0;
`ifdef BLINK_EN
            r_phase <= 1'b0;
`endif
          end else if (bus.Start) begin
            r_len   <= w_len_clamp;
            r_pos   <= '0;
            r_tick  <= '0;
`ifdef BLINK_EN
            r_phase <= 1'b0;
`endif
          end else if (!bus.Hold) begin
            if (w_tc) begin
              r_tick <= '0;
              r_pos  <= w_pos_next;
              r_step <= 1'b1;
`ifdef BLINK_EN
              if (bus.Blink) r_phase <= ~r_phase;
`endif
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
`ifdef BLINK_EN
          if (!bus.Blink) r_phase <= 1'b0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy      = (r_state == ST_SCROLL);
  assign bus.StepPulse = r_step;
  assign bus.Out7b     = r_out;
endmodule

// File: tb/tb_word_scroll_display.sv
// Directed bench for word_scroll_display with TICK_DIV=4, four digits and a 16-char buffer.
module tb_word_scroll_display;
  localparam int ND = 4;
  localparam int MD = 16;
  localparam int AW = 4;

  localparam logic [6:0] S_H = 7'h0B, S_E = 7'h06, S_L = 7'h47, S_O = 7'h23;
  localparam logic [6:0] S_1 = 7'h79, S_3 = 7'h30, S_BL = 7'h7F;
  localparam logic [27:0] ALL1 = 28'hFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  word_scroll_display_if #(.AW(AW), .NUM_DIGITS(ND)) u_if ();

  word_scroll_display #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .TICK_DIV(4)) u_dut (
    .Clk (clk),
    .Rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    u_if.WrEn   = 1'b1;
    u_if.WrAddr = a;
    u_if.WrData = d;
    adv(1);
    u_if.WrEn   = 1'b0;
  endtask

  function automatic logic [27:0] w4(input logic [6:0] a, input logic [6:0] b,
                                     input logic [6:0] c, input logic [6:0] d);
    return {a, b, c, d};
  endfunction

  logic [27:0] hello_win [5];

  initial begin
    hello_win[0] = w4(S_E, S_L, S_L, S_O);
    hello_win[1] = w4(S_L, S_L, S_O, S_H);
    hello_win[2] = w4(S_L, S_O, S_H, S_E);
    hello_win[3] = w4(S_O, S_H, S_E, S_L);
    hello_win[4] = w4(S_H, S_E, S_L, S_L);

    rst = 1'b1;
    u_if.WrEn = 1'b1; u_if.WrAddr = '0; u_if.WrData = 8'h41;
    u_if.MsgLen = '0; u_if.Start = 1'b0; u_if.Stop = 1'b0; u_if.Hold = 1'b0;
`ifdef BLINK_EN
    u_if.Blink = 1'b0;
`endif
    adv(2);
    rst = 1'b0;
    u_if.WrEn = 1'b0;
    chk("rst_out", {4'h0, u_if.Out7b}, {4'h0, ALL1});
    chk("rst_busy", {31'h0, u_if.Busy}, 32'h0);
    chk("rst_step", {31'h0, u_if.StepPulse}, 32'h0);

    // Full-length message of reset spaces: busy but blank; write during reset must not land.
    u_if.MsgLen = 5'd16; u_if.Start = 1'b1; adv(1); u_if.Start = 1'b0;
    adv(1);
    chk("spaces_busy", {31'h0, u_if.Busy}, 32'h1);
    chk("spaces_out", {4'h0, u_if.Out7b}, {4'h0, ALL1});
    u_if.Stop = 1'b1; adv(1); u_if.Stop = 1'b0;
    chk("stop_busy", {31'h0, u_if.Busy}, 32'h0);

    wr(0, 8'h48); wr(1, 8'h45); wr(2, 8'h4C); wr(3, 8'h4C); wr(4, 8'h4F);
    u_if.MsgLen = 5'd5; u_if.Start = 1'b1; adv(1); u_if.Start = 1'b0;
    adv(1);
    chk("hello_first", {4'h0, u_if.Out7b}, {4'h0, w4(S_H, S_E, S_L, S_L)});
    chk("hello_nostep", {31'h0, u_if.StepPulse}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      adv(3);
      chk("hello_step", {31'h0, u_if.StepPulse}, 32'h1);
      adv(1);
      chk("hello_win", {4'h0, u_if.Out7b}, {4'h0, hello_win[i]});
      chk("hello_pulse_end", {31'h0, u_if.StepPulse}, 32'h0);
    end

    u_if.Stop = 1'b1; adv(1); u_if.Stop = 1'b0;
    wr(0, 8'h31); wr(1, 8'h33);
    u_if.MsgLen = 5'd2; u_if.Start = 1'b1; adv(1); u_if.Start = 1'b0;
    adv(1);
    chk("short_pos0", {4'h0, u_if.Out7b}, {4'h0, w4(S_1, S_3, S_1, S_3)});

    u_if.Hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      adv(1);
      chk("hold_step", {31'h0, u_if.StepPulse}, 32'h0);
      chk("hold_out", {4'h0, u_if.Out7b}, {4'h0, w4(S_1, S_3, S_1, S_3)});
    end
    u_if.Hold = 1'b0;
    adv(2);
    chk("resume_nostep", {31'h0, u_if.StepPulse}, 32'h0);
    adv(1);
    chk("resume_step", {31'h0, u_if.StepPulse}, 32'h1);
    adv(1);
    chk("short_pos1", {4'h0, u_if.Out7b}, {4'h0, w4(S_3, S_1, S_3, S_1)});

    wr(0, 8'h4B);
    chk("unmapped_latency", {4'h0, u_if.Out7b}, {4'h0, w4(S_3, S_1, S_3, S_1)});
    adv(1);
    chk("unmapped_blank", {4'h0, u_if.Out7b}, {4'h0, w4(S_3, S_BL, S_3, S_BL)});

    u_if.Start = 1'b1; u_if.Stop = 1'b1; adv(1);
    u_if.Start = 1'b0; u_if.Stop = 1'b0;
    chk("startstop_busy", {31'h0, u_if.Busy}, 32'h0);
    adv(1);
    chk("startstop_out", {4'h0, u_if.Out7b}, {4'h0, ALL1});

    u_if.MsgLen = '0; u_if.Start = 1'b1; adv(1); u_if.Start = 1'b0;
    chk("len0_busy", {31'h0, u_if.Busy}, 32'h0);
    adv(1);
    chk("len0_out", {4'h0, u_if.Out7b}, {4'h0, ALL1});

`ifdef BLINK_EN
    u_if.Blink = 1'b1;
    u_if.MsgLen = 5'd2; u_if.Start = 1'b1; adv(1); u_if.Start = 1'b0;
    adv(1);
    chk("blink_phase0", {4'h0, u_if.Out7b}, {4'h0, w4(S_BL, S_3, S_BL, S_3)});
    adv(3);
    chk("blink_step", {31'h0, u_if.StepPulse}, 32'h1);
    adv(1);
    chk("blink_blank", {4'h0, u_if.Out7b}, {4'h0, ALL1});
    adv(4);
    chk("blink_back", {4'h0, u_if.Out7b}, {4'h0, w4(S_BL, S_3, S_BL, S_3)});
    u_if.Blink = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
